// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master controller slice.
//   - command encodings carried in the 3-bit frame header
//   - header/payload lengths
//   - FSM state enum (also exported on the controller's debug port)
//   - frame_word(): builds the 11-bit serial word {cmd[1], cmd[1], cmd[0], din}
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int HEAD_LEN   = 3;
    localparam int DATA_LEN   = 8;
    localparam int FRAME_BITS = HEAD_LEN + DATA_LEN;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HEAD = 3'd1,
        DATA = 3'd2,
        TAIL = 3'd3,
        GAP  = 3'd4
    } state_t;

    // The header repeats cmd[1] so the slave sees a start bit that equals
    // the read/write flag before the two command bits proper.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [1:0] cmd,
                                                         input logic [7:0] din);
        return {cmd[1], cmd[1], cmd[0], din};
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// spi_shifter: datapath of the SPI master.
//   11-bit PISO holding the outgoing frame (MSB first) and an 8-bit SIPO
//   collecting MISO samples (MSB first), plus the rx_data holding register.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             capture frame_word(cmd, din) into the PISO, clear SIPO
//   cmd, din         command and payload captured on load
//   shift_en         advance the PISO by one bit
//   sample_en        shift one MISO sample into the SIPO
//   rx_load          update rx_data with the SIPO contents including the
//                    sample taken on this same edge
//   miso             serial input from the slave
//   tx_bit           current PISO MSB (bit being presented on MOSI)
//   rx_data          byte captured by the most recent read-data frame
module spi_shifter
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] cmd,
    input  logic [7:0] din,
    input  logic       shift_en,
    input  logic       sample_en,
    input  logic       rx_load,
    input  logic       miso,
    output logic       tx_bit,
    output logic [7:0] rx_data
);

    logic [FRAME_BITS-1:0] piso_q;
    logic [DATA_LEN-1:0]   sipo_q;
    logic [DATA_LEN-1:0]   sipo_next;

    // The eighth sample lands on the same edge that enters GAP, so rx_data
    // is loaded from the post-shift value rather than from sipo_q.
    assign sipo_next = {sipo_q[DATA_LEN-2:0], miso};
    assign tx_bit    = piso_q[FRAME_BITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            piso_q  <= '0;
            sipo_q  <= '0;
            rx_data <= 8'h00;
        end else begin
            if (load) begin
                piso_q <= frame_word(cmd, din);
            end else if (shift_en) begin
                piso_q <= {piso_q[FRAME_BITS-2:0], 1'b0};
            end

            if (load) begin
                sipo_q <= '0;
            end else if (sample_en) begin
                sipo_q <= sipo_next;
            end

            if (rx_load) begin
                rx_data <= sipo_next;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-clock SPI master issuing 11-bit command frames.
//   Frame: 3 header bits {cmd[1], cmd[1], cmd[0]} then 8 payload bits, MSB
//   first, one bit per clk. Read-data frames (cmd=11) send zeros as payload
//   and collect 8 MISO samples starting RD_LAT cycles after the header,
//   stretching SS_n low by RD_LAT-1 TAIL cycles. SS_n then stays high for
//   GAP_CYCLES cycles before the next frame may start.
// Parameters:
//   GAP_CYCLES  SS_n-high cycles after each frame, 1..16
//   RD_LAT      header-to-first-MISO-sample latency in cycles, 1..4
// Ports:
//   clk, rst    clock (also the SPI bit clock), synchronous active-high reset
//   start       request; accepted only while busy=0
//   cmd, din    command and payload, registered on acceptance
//   busy        high from acceptance through the last GAP cycle
//   done        one-cycle pulse in the first GAP cycle
//   rx_data     byte captured by the last read-data frame
//   MOSI, SS_n  serial output and active-low slave select
//   MISO        serial input
//   dbg_state   current FSM state (spi_pkg::state_t encoding)
//
// Handshake: start is a request qualified by busy. A cycle with start=1 and
// busy=0 is accepted on that rising edge; any start seen while busy=1 is
// dropped, not queued. done marks completion; rx_data is valid from the done
// cycle until the next read-data frame completes.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int RD_LAT     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       MOSI,
    output logic       SS_n,
    input  logic       MISO,
    output logic [2:0] dbg_state
);

    localparam logic [3:0] HEAD_LAST    = 4'(HEAD_LEN - 1);
    localparam logic [3:0] DATA_LAST    = 4'(DATA_LEN - 1);
    localparam logic [3:0] TAIL_LAST    = 4'(RD_LAT - 2);
    localparam logic [3:0] GAP_LAST     = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] SAMPLE_FIRST = 4'(RD_LAT - 1);
    localparam bit         HAS_TAIL     = (RD_LAT > 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [1:0] cmd_q;
    logic       accept;
    logic       is_rd;
    logic       tx_bit;
    logic       shift_en;
    logic       sample_en;
    logic       rx_load;

    assign accept    = (state_q == IDLE) && start;
    assign is_rd     = (cmd_q == CMD_RD_DATA);
    assign dbg_state = state_q;

    // State register, per-state bit counter and registered command.
    // The counter restarts on every state change and is held at zero in
    // IDLE, so within a state it only ever counts up to that state's length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= CMD_WR_ADDR;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || (state_q == IDLE)) begin
                cnt_q <= 4'd0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (accept) begin
                cmd_q <= cmd;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = HEAD;
            HEAD: if (cnt_q == HEAD_LAST) state_d = DATA;
            DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = (is_rd && HAS_TAIL) ? TAIL : GAP;
                end
            end
            TAIL: if (cnt_q == TAIL_LAST) state_d = GAP;
            GAP:  if (cnt_q == GAP_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath-control logic.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == GAP) && (cnt_q == 4'd0);
        SS_n      = 1'b1;
        MOSI      = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        rx_load   = 1'b0;
        unique case (state_q)
            HEAD: begin
                SS_n     = 1'b0;
                MOSI     = tx_bit;
                shift_en = 1'b1;
            end
            DATA: begin
                SS_n     = 1'b0;
                MOSI     = is_rd ? 1'b0 : tx_bit;
                shift_en = 1'b1;
                // Samples start RD_LAT edges after the last header edge.
                sample_en = is_rd && (cnt_q >= SAMPLE_FIRST);
                rx_load   = is_rd && !HAS_TAIL && (cnt_q == DATA_LAST);
            end
            TAIL: begin
                SS_n      = 1'b0;
                sample_en = 1'b1;
                rx_load   = (cnt_q == TAIL_LAST);
            end
            default: begin
            end
        endcase
    end

    spi_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .cmd       (cmd),
        .din       (din),
        .shift_en  (shift_en),
        .sample_en (sample_en),
        .rx_load   (rx_load),
        .miso      (MISO),
        .tx_bit    (tx_bit),
        .rx_data   (rx_data)
    );

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl. Two instances: u_dut0 (GAP_CYCLES=1, RD_LAT=1)
// and u_dut1 (GAP_CYCLES=3, RD_LAT=2), each attached to a behavioural slave
// with a 256-byte memory and an address register. Expected frame shapes and
// read results come from a frame-level model of the protocol.
module tb_spi_master_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v;
    logic [1:0] start_v;
    logic [1:0] miso_v;
    logic [1:0] cmd0, cmd1;
    logic [7:0] din0, din1;
    wire  [1:0] busy_w, done_w, mosi_w, ss_n_w;
    wire  [7:0] rx0, rx1;
    wire  [2:0] st0, st1;

    int tests = 0;
    int fails = 0;

    spi_master_ctrl #(.GAP_CYCLES(1), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .cmd(cmd0), .din(din0),
        .busy(busy_w[0]), .done(done_w[0]), .rx_data(rx0), .MOSI(mosi_w[0]),
        .SS_n(ss_n_w[0]), .MISO(miso_v[0]), .dbg_state(st0)
    );

    spi_master_ctrl #(.GAP_CYCLES(3), .RD_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .cmd(cmd1), .din(din1),
        .busy(busy_w[1]), .done(done_w[1]), .rx_data(rx1), .MOSI(mosi_w[1]),
        .SS_n(ss_n_w[1]), .MISO(miso_v[1]), .dbg_state(st1)
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] rx_of(input int i);
        return (i == 0) ? rx0 : rx1;
    endfunction

    function automatic logic [2:0] st_of(input int i);
        return (i == 0) ? st0 : st1;
    endfunction

    function automatic string tg(input int i, input string s);
        return $sformatf("u%0d_%s", i, s);
    endfunction

    // ---------------- scoreboard / reference model ----------------
    logic [7:0] exp_mem  [2][256];
    logic [7:0] exp_addr [2];
    logic [7:0] exp_rx   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    // Watches MOSI on falling edges while SS_n is low. After the header it
    // knows the command; for read-data it presents the addressed byte MSB
    // first so each bit is stable across the master's sampling edge.
    // Outside that window MISO carries random noise.
    int         s_nb  [2];
    logic [10:0] s_sh [2];
    logic [1:0] s_cmd [2];
    logic [7:0] s_addr[2];
    logic [7:0] s_rd  [2];
    logic [7:0] s_mem [2][256];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ss_n_w[i]) begin
                s_nb[i]   = 0;
                miso_v[i] = 1'($urandom_range(0, 1));
            end else begin
                s_sh[i] = {s_sh[i][9:0], mosi_w[i]};
                if (s_nb[i] == 2) begin
                    s_cmd[i] = s_sh[i][1:0];
                    s_rd[i]  = s_mem[i][s_addr[i]];
                end
                if (s_nb[i] >= 3 && s_cmd[i] == 2'b11 &&
                    s_nb[i] >= 2 + lat_of(i) && s_nb[i] <= 9 + lat_of(i)) begin
                    miso_v[i] = s_rd[i][9 + lat_of(i) - s_nb[i]];
                end else begin
                    miso_v[i] = 1'($urandom_range(0, 1));
                end
                if (s_nb[i] == 10) begin
                    case (s_sh[i][9:8])
                        2'b00, 2'b10: s_addr[i] = s_sh[i][7:0];
                        2'b01:        s_mem[i][s_addr[i]] = s_sh[i][7:0];
                        default: ;
                    endcase
                end
                s_nb[i]++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int i, input logic s, input logic [1:0] c, input logic [7:0] d);
        start_v[i] = s;
        if (i == 0) begin
            cmd0 = c;
            din0 = d;
        end else begin
            cmd1 = c;
            din1 = d;
        end
    endtask

    // Issues one frame starting in the current (idle) cycle and follows it
    // until busy drops, returning in that idle cycle so a following call is
    // back-to-back. poke>0 re-asserts start with junk in that frame cycle.
    task automatic do_frame(input int i, input logic [1:0] c, input logic [7:0] d, input int poke);
        int         len, gap, nlow, ndone, done_at, nbusy, cyc;
        logic [10:0] bits, exp_bits;
        logic       ext_ok, idle_ok, contig;
        logic [7:0] rx_at_done;

        len      = (c == 2'b11) ? 10 + lat_of(i) : 11;
        gap      = gap_of(i);
        exp_bits = {c[1], c[1], c[0], (c == 2'b11) ? 8'h00 : d};
        case (c)
            2'b00, 2'b10: exp_addr[i] = d;
            2'b01:        exp_mem[i][exp_addr[i]] = d;
            default:      exp_rx[i] = exp_mem[i][exp_addr[i]];
        endcase

        nlow = 0; ndone = 0; done_at = 0; nbusy = 0; cyc = 0;
        bits = '0; ext_ok = 1'b1; idle_ok = 1'b1; contig = 1'b1; rx_at_done = 8'h00;

        drive(i, 1'b1, c, d);
        while (cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) drive(i, 1'b0, ~c, ~d);
            if (poke > 0 && cyc == poke)
                drive(i, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            if (poke > 0 && cyc == poke + 1) drive(i, 1'b0, c, d);
            if (!busy_w[i]) break;
            nbusy++;
            if (!ss_n_w[i]) begin
                nlow++;
                if (nlow != cyc) contig = 1'b0;
                if (nlow <= 11) bits = {bits[9:0], mosi_w[i]};
                else if (mosi_w[i] !== 1'b0) ext_ok = 1'b0;
            end else if (mosi_w[i] !== 1'b0) begin
                idle_ok = 1'b0;
            end
            if (done_w[i]) begin
                ndone++;
                done_at    = cyc;
                rx_at_done = rx_of(i);
            end
        end

        check(tg(i, "busy_cycles"), 32'(nbusy), 32'(len + gap));
        check(tg(i, "ss_low_cycles"), 32'(nlow), 32'(len));
        check(tg(i, "ss_low_contig"), 32'(contig), 32'd1);
        check(tg(i, "mosi_bits"), 32'(bits), 32'(exp_bits));
        check(tg(i, "mosi_ext_zero"), 32'(ext_ok), 32'd1);
        check(tg(i, "mosi_gap_zero"), 32'(idle_ok), 32'd1);
        check(tg(i, "done_count"), 32'(ndone), 32'd1);
        check(tg(i, "done_cycle"), 32'(done_at), 32'(len + 1));
        check(tg(i, "rx_at_done"), 32'(rx_at_done), 32'(exp_rx[i]));
        check(tg(i, "rx_after"), 32'(rx_of(i)), 32'(exp_rx[i]));
    endtask

    // Starts a frame, asserts rst during frame cycle `at`, optionally with
    // start also high, and checks the abort leaves the block idle and quiet.
    task automatic do_abort(input int i, input logic [1:0] c, input logic [7:0] d,
                            input int at, input logic with_start);
        int bad;
        drive(i, 1'b1, c, d);
        for (int cyc = 1; cyc <= at; cyc++) begin
            @(negedge clk);
            if (cyc == 1) drive(i, 1'b0, c, d);
        end
        rst_v[i] = 1'b1;
        if (with_start) drive(i, 1'b1, c, d);
        @(negedge clk);
        rst_v[i] = 1'b0;
        drive(i, 1'b0, c, d);
        exp_rx[i] = 8'h00;
        check(tg(i, "abort_ss_n"), 32'(ss_n_w[i]), 32'd1);
        check(tg(i, "abort_busy"), 32'(busy_w[i]), 32'd0);
        check(tg(i, "abort_done"), 32'(done_w[i]), 32'd0);
        check(tg(i, "abort_mosi"), 32'(mosi_w[i]), 32'd0);
        check(tg(i, "abort_rx"), 32'(rx_of(i)), 32'h00);
        check(tg(i, "abort_state"), 32'(st_of(i)), 32'd0);
        bad = 0;
        repeat (24) begin
            @(negedge clk);
            if (done_w[i] !== 1'b0 || ss_n_w[i] !== 1'b1 || busy_w[i] !== 1'b0) bad++;
        end
        check(tg(i, "abort_quiet"), 32'(bad), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 256; j++) begin
                s_mem[i][j]   = 8'(j * 37 + 11 + i);
                exp_mem[i][j] = 8'(j * 37 + 11 + i);
            end
            s_mem[i][8'h69]   = 8'hB3;
            exp_mem[i][8'h69] = 8'hB3;
            s_addr[i]   = 8'h00;
            exp_addr[i] = 8'h00;
            exp_rx[i]   = 8'h00;
            s_nb[i]     = 0;
            s_cmd[i]    = 2'b00;
            s_sh[i]     = '0;
        end

        rst_v   = 2'b11;
        start_v = 2'b11;
        cmd0 = 2'b11; din0 = 8'hA5;
        cmd1 = 2'b11; din1 = 8'h5A;
        repeat (3) @(negedge clk);
        start_v = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check(tg(i, "rst_ss_n"), 32'(ss_n_w[i]), 32'd1);
            check(tg(i, "rst_mosi"), 32'(mosi_w[i]), 32'd0);
            check(tg(i, "rst_busy"), 32'(busy_w[i]), 32'd0);
            check(tg(i, "rst_done"), 32'(done_w[i]), 32'd0);
            check(tg(i, "rst_rx"), 32'(rx_of(i)), 32'h00);
            check(tg(i, "rst_state"), 32'(st_of(i)), 32'd0);
        end
        rst_v = 2'b00;
        @(negedge clk);
        check(tg(0, "idle_after_rst"), 32'(busy_w[0]), 32'd0);

        // Write address / write data patterns, back-to-back.
        do_frame(0, 2'b00, 8'h69, 0);
        do_frame(0, 2'b01, 8'hB3, 0);
        // Read back address 69h.
        repeat (2) @(negedge clk);
        do_frame(0, 2'b10, 8'h69, 0);
        do_frame(0, 2'b11, 8'h00, 0);
        // Back-to-back write then read of FFh.
        do_frame(0, 2'b00, 8'hFF, 0);
        do_frame(0, 2'b01, 8'h01, 0);
        do_frame(0, 2'b10, 8'hFF, 0);
        do_frame(0, 2'b11, 8'h7E, 0);
        // Start pulsed mid-frame is ignored.
        do_frame(0, 2'b00, 8'h5A, 5);
        do_frame(0, 2'b11, 8'h00, 7);
        // Reset during DATA bit 4 on both instances.
        do_abort(0, 2'b11, 8'h00, 8, 1'b0);
        do_abort(1, 2'b01, 8'hC3, 8, 1'b1);
        // Longer-latency instance reads 69h after the abort.
        do_frame(1, 2'b10, 8'h69, 0);
        do_frame(1, 2'b11, 8'h00, 0);
        do_frame(1, 2'b01, 8'h3C, 0);
        do_frame(1, 2'b11, 8'h00, 4);

        // Randomized frames across both instances.
        for (int n = 0; n < 80; n++) begin
            int         i;
            int         poke;
            logic [1:0] c;
            logic [7:0] d;
            i = $urandom_range(0, 1);
            c = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d = 8'h69;
            poke = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 9) : 0;
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            do_frame(i, c, d, poke);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1: cycles SS_n is held high after each frame, minimum 1.
REQ-002 SHALL have parameter RD_LAT, default 1: cycles from the 3rd header-bit edge to the first MISO sample, range 1..4.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic samples on the rising edge; it also serves as the SPI bit clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: transaction request, honoured only while busy=0.
REQ-006 SHALL have port cmd, input, 2 bits: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-007 SHALL have port din, input, 8 bits: address or data payload; don't-care for cmd=11.
REQ-008 SHALL have port busy, output, 1 bit: transaction in progress, including the gap cycles.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rx_data, output, 8 bits: byte captured by the last cmd=11 frame.
REQ-011 SHALL have port MOSI, output, 1 bit: serial data to the slave.
REQ-012 SHALL have port SS_n, output, 1 bit: active-low slave select.
REQ-013 SHALL have port MISO, input, 1 bit: serial data from the slave.

Function
REQ-014 SHALL register cmd and din on the edge where start=1 and busy=0, and set busy=1 on that same edge.
REQ-015 SHALL hold SS_n=0 from the next cycle onward for exactly 11 cycles (cmd 00/01/10), or 11+RD_LAT-1 cycles (cmd 11).
REQ-016 SHALL drive one MOSI bit per cycle in this order: cmd[1], cmd[1], cmd[0], din[7]..din[0], MSB first.
REQ-017 SHALL, for cmd=11, drive MOSI=0 on all payload and extension cycles.
REQ-018 SHALL use FSM states IDLE -> HEAD (3 cycles) -> DATA (8 cycles) -> TAIL (RD_LAT-1 cycles, cmd=11 only; skipped when RD_LAT=1) -> GAP (GAP_CYCLES) -> IDLE.
REQ-019 SHALL hold SS_n=1 and MOSI=0 in IDLE and GAP.
REQ-020 SHALL, for cmd=11, shift in 8 MISO samples MSB first on consecutive edges.
REQ-021 SHALL take the first MISO sample RD_LAT cycles after the edge ending the 3rd header cycle.
REQ-022 SHALL load rx_data from the shift register on entry to GAP.
REQ-023 SHALL leave rx_data unchanged for cmd 00/01/10.
REQ-024 SHALL pulse done=1 for exactly the first GAP cycle; rx_data SHALL be valid in that cycle.
REQ-025 SHALL hold busy=1 from the acceptance edge through the last GAP cycle.
REQ-026 SHALL accept a start presented in the cycle busy returns to 0, with no additional idle cycle.
REQ-027 SHALL ignore start while busy=1; the request is not queued and in-flight cmd/din are unchanged.
REQ-028 SHALL count bits with a 4-bit counter that is cleared on each state entry and never wraps within a state.

Reset
REQ-029 SHALL, on rst=1 at a rising edge, force the next-cycle values state=IDLE, SS_n=1, MOSI=0, busy=0, done=0, rx_data=8'h00, and clear the counter and shift registers.
REQ-030 SHALL, on reset mid-frame, abort the frame, raise SS_n immediately with no GAP, generate no done pulse, and leave rx_data=0.
REQ-031 SHALL let rst dominate start asserted in the same cycle.

Structure
REQ-032 SHALL place the command encodings CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA, HEAD_LEN=3, DATA_LEN=8, and the state enum in shared package spi_pkg.
REQ-033 SHALL place the 11-bit PISO plus 8-bit SIPO datapath in one sub-module, spi_shifter; the FSM stays in spi_master_ctrl.

Verification
REQ-034 SHALL cover: start, cmd=00, din=8'h69 -> SS_n low 11 cycles, MOSI 0,0,0,0,1,1,0,1,0,0,1, SS_n high 1 cycle, done once, rx_data unchanged.
REQ-035 SHALL cover: cmd=01, din=8'hB3 -> MOSI 0,0,1,1,0,1,1,0,0,1,1.
REQ-036 SHALL cover: cmd=10, din=8'h69, then cmd=11 against the SPI_Top slave preloaded so address 69h holds B3h -> header MOSI 1,1,1, rx_data=8'hB3 at done.
REQ-037 SHALL cover: cmd=00, din=8'hFF, then cmd=01, din=8'h01, then cmd=10/11 at FFh -> rx_data=8'h01, with each start issued in the cycle busy falls (back-to-back).
REQ-038 SHALL cover: start pulsed at cycle 5 of a frame -> ignored, frame bits unchanged, exactly one done.
REQ-039 SHALL cover: rst asserted at DATA bit 4 -> next cycle SS_n=1, busy=0, done never pulses, rx_data=00h; a following cmd=11 with RD_LAT=2 completes correctly.
